// File: rtl/fetch_sequencer.sv
// Fetch/sequencing companion of the multicycle control FSM: owns the state register and the PC,
// and performs instruction fetch over a req/ack handshake with a bounded wait.
module fetch_sequencer #(
    parameter int unsigned        INSTR_W      = 64,
    parameter int unsigned        ADDR_W       = 64,
    parameter logic [3:0]         FETCH_STATE  = 4'd0,
    parameter logic [3:0]         DECODE_STATE = 4'd1,
    parameter logic [3:0]         ERROR_STATE  = 4'd15,
    parameter logic [ADDR_W-1:0]  RESET_PC     = '0,
    parameter int unsigned        WAIT_LIMIT   = 16
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic [3:0]         NSTATE,
    input  logic               HALT,
    input  logic               PC_LOAD,
    input  logic [ADDR_W-1:0]  PC_TARGET,
    input  logic               IMEM_ACK,
    input  logic [INSTR_W-1:0] IMEM_RDATA,
    output logic [3:0]         STATE,
    output logic [INSTR_W-1:0] INSTRUCTION,
    output logic [ADDR_W-1:0]  PC,
    output logic               IMEM_REQ,
    output logic [ADDR_W-1:0]  IMEM_ADDR,
    output logic               FETCH_ERR,
    output logic [31:0]        INSTR_COUNT
);

    localparam int unsigned CNT_W = $clog2(WAIT_LIMIT + 1);

    logic [3:0]         state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               req_q, req_d;
    logic               err_q, err_d;
    logic [31:0]        count_q, count_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]   wait_inc;
    logic               timeout;

    assign wait_inc = wait_q + CNT_W'(1);
    assign timeout  = (wait_inc == CNT_W'(WAIT_LIMIT));

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        req_d   = req_q;
        err_d   = err_q;
        count_d = count_q;
        wait_d  = wait_q;
        if (state_q == FETCH_STATE) begin
            if (req_q) begin
                // An ack takes priority over a timeout landing on the same cycle.
                if (IMEM_ACK) begin
                    instr_d = IMEM_RDATA;
                    pc_d    = pc_q + ADDR_W'(4);
                    count_d = count_q + 32'd1;
                    req_d   = 1'b0;
                    state_d = DECODE_STATE;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_inc;
                    if (timeout) begin
                        req_d   = 1'b0;
                        err_d   = 1'b1;
                        state_d = ERROR_STATE;
                    end
                end
            end else if (!HALT) begin
                req_d = 1'b1;
            end
        end else if (state_q != ERROR_STATE) begin
            state_d = NSTATE;
            req_d   = 1'b0;
            if (PC_LOAD) begin
                pc_d = PC_TARGET;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= FETCH_STATE;
            instr_q <= '0;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            err_q   <= err_d;
            count_q <= count_d;
            wait_q  <= wait_d;
        end
    end

    assign STATE       = state_q;
    assign INSTRUCTION = instr_q;
    assign PC          = pc_q;
    assign IMEM_REQ    = req_q;
    assign IMEM_ADDR   = pc_q;
    assign FETCH_ERR   = err_q;
    assign INSTR_COUNT = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a reference model checked every cycle plus literal
// expectations for the fetch, branch, timeout, halt, reset and wrap scenarios.
module tb_fetch_sequencer;

    logic        CLOCK;
    logic        RESET;
    logic [3:0]  NSTATE;
    logic        HALT;
    logic        PC_LOAD;
    logic [63:0] PC_TARGET;
    logic        IMEM_ACK;
    logic [63:0] IMEM_RDATA;
    logic [3:0]  STATE;
    logic [63:0] INSTRUCTION;
    logic [63:0] PC;
    logic        IMEM_REQ;
    logic [63:0] IMEM_ADDR;
    logic        FETCH_ERR;
    logic [31:0] INSTR_COUNT;

    fetch_sequencer dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .NSTATE      (NSTATE),
        .HALT        (HALT),
        .PC_LOAD     (PC_LOAD),
        .PC_TARGET   (PC_TARGET),
        .IMEM_ACK    (IMEM_ACK),
        .IMEM_RDATA  (IMEM_RDATA),
        .STATE       (STATE),
        .INSTRUCTION (INSTRUCTION),
        .PC          (PC),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .FETCH_ERR   (FETCH_ERR),
        .INSTR_COUNT (INSTR_COUNT)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: phase of the fetch transaction plus architectural registers.
    bit          m_valid = 1'b0;
    int          m_state;
    logic [63:0] m_pc;
    logic [63:0] m_instr;
    bit          m_req;
    bit          m_err;
    int unsigned m_count;
    int          m_waited;

    always @(posedge CLOCK) begin
        if (RESET) begin
            m_valid  = 1'b1;
            m_state  = 0;
            m_pc     = 64'd0;
            m_instr  = 64'd0;
            m_req    = 1'b0;
            m_err    = 1'b0;
            m_count  = 0;
            m_waited = 0;
        end else if (m_valid) begin
            if (m_state == 15) begin
                // Terminal until reset.
            end else if (m_state == 0 && m_req && IMEM_ACK) begin
                m_instr  = IMEM_RDATA;
                m_pc     = m_pc + 64'd4;
                m_count  = m_count + 1;
                m_req    = 1'b0;
                m_waited = 0;
                m_state  = 1;
            end else if (m_state == 0 && m_req) begin
                m_waited = m_waited + 1;
                if (m_waited >= 16) begin
                    m_req   = 1'b0;
                    m_err   = 1'b1;
                    m_state = 15;
                end
            end else if (m_state == 0) begin
                if (!HALT) m_req = 1'b1;
            end else begin
                if (PC_LOAD) m_pc = PC_TARGET;
                m_state = int'(NSTATE);
            end
        end
    end

    always @(negedge CLOCK) begin
        if (m_valid) begin
            check("model_state", 64'(STATE), 64'(m_state));
            check("model_pc", PC, m_pc);
            check("model_addr", IMEM_ADDR, m_pc);
            check("model_instr", INSTRUCTION, m_instr);
            check("model_req", 64'(IMEM_REQ), 64'(m_req));
            check("model_err", 64'(FETCH_ERR), 64'(m_err));
            check("model_count", 64'(INSTR_COUNT), 64'(m_count));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    initial begin
        RESET = 1'b1; NSTATE = 4'd0; HALT = 1'b0; PC_LOAD = 1'b0;
        PC_TARGET = 64'd0; IMEM_ACK = 1'b0; IMEM_RDATA = 64'd0;
        tick(2);
        check("rst_state", 64'(STATE), 64'd0);
        check("rst_pc", PC, 64'd0);
        check("rst_req", 64'(IMEM_REQ), 64'd0);
        check("rst_instr", INSTRUCTION, 64'd0);
        check("rst_err", 64'(FETCH_ERR), 64'd0);
        check("rst_count", 64'(INSTR_COUNT), 64'd0);

        // Basic fetch with a one-cycle ack.
        RESET = 1'b0; IMEM_RDATA = 64'hF8000001;
        tick(1);
        check("f1_req_up", 64'(IMEM_REQ), 64'd1);
        check("f1_addr", IMEM_ADDR, 64'd0);
        IMEM_ACK = 1'b1;
        tick(1);
        IMEM_ACK = 1'b0;
        check("f1_instr", INSTRUCTION, 64'hF8000001);
        check("f1_pc", PC, 64'd4);
        check("f1_state", 64'(STATE), 64'd1);
        check("f1_count", 64'(INSTR_COUNT), 64'd1);
        check("f1_req_down", 64'(IMEM_REQ), 64'd0);

        // Sequence 2,3,0 with a branch taken out of state 3.
        NSTATE = 4'd2; tick(1);
        NSTATE = 4'd3; tick(1);
        check("br_state3", 64'(STATE), 64'd3);
        NSTATE = 4'd0; PC_LOAD = 1'b1; PC_TARGET = 64'h100; tick(1);
        PC_LOAD = 1'b0;
        check("br_pc", PC, 64'h100);
        check("br_state0", 64'(STATE), 64'd0);
        tick(1);
        check("br_req", 64'(IMEM_REQ), 64'd1);
        check("br_addr", IMEM_ADDR, 64'h100);
        IMEM_RDATA = 64'h8B020020; IMEM_ACK = 1'b1; tick(1);
        IMEM_ACK = 1'b0;
        check("br_pc4", PC, 64'h104);

        // Ack withheld: timeout after exactly 16 request-high cycles.
        NSTATE = 4'd0; tick(1);
        tick(1);
        check("to_req_up", 64'(IMEM_REQ), 64'd1);
        tick(15);
        check("to_still_waiting", 64'(STATE), 64'd0);
        check("to_req_15", 64'(IMEM_REQ), 64'd1);
        tick(1);
        check("to_state", 64'(STATE), 64'd15);
        check("to_err", 64'(FETCH_ERR), 64'd1);
        check("to_req_down", 64'(IMEM_REQ), 64'd0);
        IMEM_ACK = 1'b1; IMEM_RDATA = 64'hDEAD; tick(3);
        IMEM_ACK = 1'b0;
        check("to_late_ack_instr", INSTRUCTION, 64'h8B020020);
        check("to_late_ack_count", 64'(INSTR_COUNT), 64'd2);
        check("to_state_hold", 64'(STATE), 64'd15);
        RESET = 1'b1; tick(1);
        RESET = 1'b0;
        check("to_rst_err", 64'(FETCH_ERR), 64'd0);
        check("to_rst_state", 64'(STATE), 64'd0);

        // Ack on the 16th wait cycle still completes normally.
        tick(1);
        tick(15);
        IMEM_ACK = 1'b1; IMEM_RDATA = 64'h1234; tick(1);
        IMEM_ACK = 1'b0;
        check("edge_state", 64'(STATE), 64'd1);
        check("edge_err", 64'(FETCH_ERR), 64'd0);
        check("edge_instr", INSTRUCTION, 64'h1234);
        check("edge_pc", PC, 64'd4);

        // HALT before the request holds it off; HALT after the request is ignored.
        NSTATE = 4'd0; HALT = 1'b1; tick(1);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("halt_req_low", 64'(IMEM_REQ), 64'd0);
        end
        HALT = 1'b0; tick(1);
        check("halt_req_up", 64'(IMEM_REQ), 64'd1);
        HALT = 1'b1; tick(3);
        IMEM_ACK = 1'b1; IMEM_RDATA = 64'h55; tick(1);
        IMEM_ACK = 1'b0; HALT = 1'b0;
        check("halt_done_state", 64'(STATE), 64'd1);
        check("halt_done_count", 64'(INSTR_COUNT), 64'd2);
        check("halt_done_pc", PC, 64'd8);

        // Reset in the middle of a wait.
        NSTATE = 4'd0; tick(1);
        tick(6);
        RESET = 1'b1; tick(1);
        RESET = 1'b0;
        check("mid_rst_req", 64'(IMEM_REQ), 64'd0);
        check("mid_rst_pc", PC, 64'd0);

        // PC wraps past 2^64-4.
        tick(1);
        IMEM_ACK = 1'b1; tick(1);
        IMEM_ACK = 1'b0;
        NSTATE = 4'd0; PC_LOAD = 1'b1; PC_TARGET = 64'hFFFF_FFFF_FFFF_FFFC; tick(1);
        PC_LOAD = 1'b0;
        tick(1);
        check("wrap_addr", IMEM_ADDR, 64'hFFFF_FFFF_FFFF_FFFC);
        IMEM_ACK = 1'b1; IMEM_RDATA = 64'h77; tick(1);
        IMEM_ACK = 1'b0;
        check("wrap_pc", PC, 64'd0);
        check("wrap_count", 64'(INSTR_COUNT), 64'd2);
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
